divisor_sequencial: RTL and testbench

- Parametrised sequential restoring divider: unsigned WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
- Successor to the combinational per-row subtractor stages: a single (WIDTH+1)-bit trial subtractor is reused across WIDTH cycles.
- Adds a start/busy/done handshake and divide-by-zero detection.
- Sits in the arithmetic datapath beside the adder/subtractor blocks and is driven by the control FSM.

---
 rtl/divisor_sequencial.sv | 118 +++++++++++
 tb/tb_divisor_sequencial.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_sequencial.sv
// Sequential restoring divider: one quotient bit per clock using a single
// (WIDTH+1)-bit trial subtractor. Start/busy/done handshake plus a
// divide-by-zero flag. Published results only change on completion.
//
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | iterating, one quotient bit per edge
//   DONE  | results valid, done high for this single cycle
module divisor_sequencial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quociente,
  output logic [WIDTH-1:0] resto,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  // The partial remainder is always below the divisor after an update, so
  // WIDTH bits suffice to hold it; the extra bit lives only in the trial.
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   t;
  logic             borrow;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and one restoring-division step.
  always_comb begin
    state_next = state;
    rs         = {r_reg, q_reg[WIDTH-1]};
    t          = rs - {1'b0, d_reg};
    borrow     = t[WIDTH];
    q_next     = {q_reg[WIDTH-2:0], ~borrow};
    r_next     = borrow ? rs[WIDTH-1:0] : t[WIDTH-1:0];
    case (state)
      IDLE, DONE: begin
        if (start) state_next = (divisor != '0) ? CALC : DONE;
        else       state_next = IDLE;
      end
      CALC: begin
        if (cnt == LAST) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  // Operand capture, iteration and result publication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      cnt       <= '0;
      quociente <= '0;
      resto     <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor != '0) begin
              q_reg    <= dividendo;
              d_reg    <= divisor;
              r_reg    <= '0;
              cnt      <= '0;
              div_zero <= 1'b0;
            end else begin
              quociente <= '1;
              resto     <= dividendo;
              div_zero  <= 1'b1;
            end
          end
        end
        CALC: begin
          q_reg <= q_next;
          r_reg <= r_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            quociente <= q_next;
            resto     <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_sequencial.sv
// Directed + random bench for divisor_sequencial at WIDTH=8 and WIDTH=16.
module tb_divisor_sequencial;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  dividendo8 = '0, divisor8 = '0;
  logic [7:0]  quociente8, resto8;
  logic        busy8, done8, div_zero8;

  logic        start16 = 1'b0;
  logic [15:0] dividendo16 = '0, divisor16 = '0;
  logic [15:0] quociente16, resto16;
  logic        busy16, done16, div_zero16;

  int total = 0;
  int bad = 0;
  exp_t sb8[$];
  exp_t sb16[$];

  always #5 clk = ~clk;

  divisor_sequencial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .dividendo(dividendo8), .divisor(divisor8),
    .quociente(quociente8), .resto(resto8),
    .busy(busy8), .done(done8), .div_zero(div_zero8)
  );

  divisor_sequencial #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16),
    .dividendo(dividendo16), .divisor(divisor16),
    .quociente(quociente16), .resto(resto16),
    .busy(busy16), .done(done16), .div_zero(div_zero16)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ones);
    exp_t e;
    if (b == 0) begin
      e.q = ones; e.r = a; e.z = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1; dividendo8 = a; divisor8 = b;
    sb8.push_back(model({24'd0, a}, {24'd0, b}, 32'hFF));
    tick();
    start8 = 1'b0;
    dividendo8 = 8'($urandom); divisor8 = 8'($urandom);
  endtask

  task automatic wait8(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = busy8 ? 1 : 0;
    while (done8 !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
      if (busy8 === 1'b1) bcnt++;
    end
    chk("done8_seen", {31'd0, done8}, 32'd1);
  endtask

  task automatic compare8(input string tag);
    exp_t e;
    chk({tag, "_sb"}, (sb8.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb8.size() > 0) begin
      e = sb8.pop_front();
      chk({tag, "_q"}, {24'd0, quociente8}, e.q);
      chk({tag, "_r"}, {24'd0, resto8}, e.r);
      chk({tag, "_z"}, {31'd0, div_zero8}, {31'd0, e.z});
    end
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b);
    start16 = 1'b1; dividendo16 = a; divisor16 = b;
    sb16.push_back(model({16'd0, a}, {16'd0, b}, 32'hFFFF));
    tick();
    start16 = 1'b0;
    dividendo16 = 16'($urandom); divisor16 = 16'($urandom);
  endtask

  task automatic wait16(output int cyc);
    cyc = 0;
    while (done16 !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("done16_seen", {31'd0, done16}, 32'd1);
  endtask

  task automatic compare16(input string tag);
    exp_t e;
    chk({tag, "_sb"}, (sb16.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb16.size() > 0) begin
      e = sb16.pop_front();
      chk({tag, "_q"}, {16'd0, quociente16}, e.q);
      chk({tag, "_r"}, {16'd0, resto16}, e.r);
      chk({tag, "_z"}, {31'd0, div_zero16}, {31'd0, e.z});
    end
  endtask

  initial begin
    int cyc, bcnt, ndone;
    logic [15:0] a, b;
    exp_t dropped;

    // reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_q", {24'd0, quociente8}, 32'd0);
    chk("rst_r", {24'd0, resto8}, 32'd0);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_dz", {31'd0, div_zero8}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 200/7: latency 8, busy for 8 samples, single done pulse
    issue8(8'd200, 8'd7);
    chk("200_busy_accept", {31'd0, busy8}, 32'd1);
    wait8(cyc, bcnt);
    chk("200_latency", cyc, 32'd8);
    chk("200_busy_cycles", bcnt, 32'd8);
    chk("200_busy_at_done", {31'd0, busy8}, 32'd0);
    compare8("200_7");
    chk({24'd0, quociente8} == 32'd28 ? "200_q28" : "200_q28", {24'd0, quociente8}, 32'd28);
    tick();
    chk("200_done_pulse", {31'd0, done8}, 32'd0);

    // 5/9 then 255/1 issued in the done cycle
    issue8(8'd5, 8'd9);
    wait8(cyc, bcnt);
    chk("5_latency", cyc, 32'd8);
    compare8("5_9");
    issue8(8'd255, 8'd1);
    chk("b2b_busy", {31'd0, busy8}, 32'd1);
    chk("b2b_done_low", {31'd0, done8}, 32'd0);
    wait8(cyc, bcnt);
    chk("255_latency", cyc, 32'd8);
    compare8("255_1");

    // 37/0: done right after accepting edge
    tick();
    issue8(8'd37, 8'd0);
    wait8(cyc, bcnt);
    chk("dz_latency", cyc, 32'd0);
    chk("dz_busy", bcnt, 32'd0);
    compare8("37_0");
    tick();
    chk("dz_done_pulse", {31'd0, done8}, 32'd0);
    chk("dz_hold", {31'd0, div_zero8}, 32'd1);
    issue8(8'd10, 8'd3);
    wait8(cyc, bcnt);
    compare8("10_3");

    // 100/3 with a stray start at iteration 4
    tick();
    issue8(8'd100, 8'd3);
    repeat (4) tick();
    start8 = 1'b1; dividendo8 = 8'd9; divisor8 = 8'd9;
    tick();
    start8 = 1'b0;
    chk("calc_hold_q", {24'd0, quociente8}, 32'd3);
    chk("calc_hold_r", {24'd0, resto8}, 32'd1);
    wait8(cyc, bcnt);
    chk("ign_latency", cyc + 5, 32'd8);
    compare8("100_3");

    // 250/6 aborted by reset at iteration 5
    tick();
    issue8(8'd250, 8'd6);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    dropped = sb8.pop_back();
    chk("abort_q", {24'd0, quociente8}, 32'd0);
    chk("abort_r", {24'd0, resto8}, 32'd0);
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_dz", {31'd0, div_zero8}, 32'd0);
    ndone = 0;
    repeat (12) begin
      tick();
      if (done8 === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);
    issue8(8'd250, 8'd6);
    wait8(cyc, bcnt);
    chk("250_latency", cyc, 32'd8);
    compare8("250_6");

    // WIDTH=16 directed
    issue16(16'd65535, 16'd255);
    wait16(cyc);
    chk("w16_latency", cyc, 32'd16);
    compare16("65535_255");

    // WIDTH=16 random sweep, back-to-back from the done cycle
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(1, 65535));
      issue16(a, b);
      wait16(cyc);
      compare16("rnd");
      chk("rnd_inv", {16'd0, quociente16} * {16'd0, b} + {16'd0, resto16}, {16'd0, a});
      chk("rnd_rem_lt", (resto16 < b) ? 32'd1 : 32'd0, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
